sync_fifo_flags: RTL and testbench

Single-clock, parametrised successor to the team's FIFO memory block. Adds these features:
- programmable almost-full and almost-empty thresholds
- occupancy count
- write-acknowledge and read-valid handshake outputs
- overflow and underflow error pulses

It buffers a data stream between a producer and a consumer in the same clock domain. Status flags are used for flow control.

---
 rtl/sync_fifo_flags.sv | 85 ++++++++
 tb/tb_sync_fifo_flags.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with programmable almost flags,
// occupancy count, handshake and error pulses.
module sync_fifo_flags #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 512,
  parameter int AF_THRESH  = FIFO_DEPTH - 4,
  parameter int AE_THRESH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FIFO_WIDTH-1:0]       din,
  input  logic                        wen,
  input  logic                        ren,
  output logic [FIFO_WIDTH-1:0]       dout,
  output logic                        dout_valid,
  output logic                        wr_ack,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic                        overflow,
  output logic                        underflow,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [PW-1:0]         cnt;
  logic                  wr_ok;
  logic                  rd_ok;

  // Flag decode from registered pointers and count
  always_comb begin
    full = (wptr[AW] != rptr[AW]) &&
           (wptr[AW-1:0] == rptr[AW-1:0]);
    empty        = (wptr == rptr);
    almost_full  = (cnt >= PW'(AF_THRESH));
    almost_empty = (cnt <= PW'(AE_THRESH));
    wr_ok        = wen && !full;
    rd_ok        = ren && !empty;
  end

  assign count = cnt;

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wptr[AW-1:0]] <= din;
  end

  // Pointers, count, read data and pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      wr_ack     <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_ok)
        wptr <= wptr + PW'(1);
      if (rd_ok) begin
        rptr <= rptr + PW'(1);
        dout <= mem[rptr[AW-1:0]];
      end
      unique case (1'b1)
        (wr_ok && !rd_ok): cnt <= cnt + PW'(1);
        (rd_ok && !wr_ok): cnt <= cnt - PW'(1);
        default:           cnt <= cnt;
      endcase
      dout_valid <= rd_ok;
      wr_ack     <= wr_ok;
      overflow   <= wen && full;
      underflow  <= ren && empty;
    end
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags,
// depth 8, AF 6, AE 2, width 16.
module tb_sync_fifo_flags;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic        wen;
  logic        ren;
  logic [15:0] dout;
  logic        dout_valid;
  logic        wr_ack;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic        overflow;
  logic        underflow;
  logic [3:0]  count;

  int nchk;
  int nerr;
  logic [15:0] q [$];
  logic [15:0] exp_w;

  sync_fifo_flags #(
    .FIFO_WIDTH(16),
    .FIFO_DEPTH(8),
    .AF_THRESH (6),
    .AE_THRESH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .wen         (wen),
    .ren         (ren),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .wr_ack      (wr_ack),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h",
               tag, act, exp);
    end
  endtask

  task automatic tick(input logic w,
                      input logic r,
                      input logic [15:0] d);
    wen = w;
    ren = r;
    din = d;
    @(posedge clk);
    #1;
    wen = 1'b0;
    ren = 1'b0;
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    rst  = 1'b1;
    wen  = 1'b0;
    ren  = 1'b0;
    din  = '0;

    // 1: reset and idle
    tick(0, 0, 0);
    tick(0, 0, 0);
    rst = 1'b0;
    tick(0, 0, 0);
    check("rst_empty", empty, 1);
    check("rst_ae", almost_empty, 1);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    check("rst_count", count, 0);
    check("rst_dout", dout, 0);
    check("rst_dv", dout_valid, 0);
    check("rst_ack", wr_ack, 0);
    check("rst_ovf", overflow, 0);
    check("rst_udf", underflow, 0);

    // 2: fill to full, then overflow
    for (int i = 1; i <= 8; i++) begin
      tick(1, 0, 16'(i));
      check("fill_ack", wr_ack, 1);
      check("fill_cnt", count, i);
      check("fill_ae", almost_empty, i <= 2);
      check("fill_af", almost_full, i >= 6);
      check("fill_full", full, i == 8);
      check("fill_empty", empty, 0);
    end
    tick(1, 0, 16'h00ff);
    check("ovf_pulse", overflow, 1);
    check("ovf_ack", wr_ack, 0);
    check("ovf_cnt", count, 8);
    tick(0, 0, 0);
    check("ovf_clear", overflow, 0);

    // 3: drain, then underflow
    for (int i = 1; i <= 8; i++) begin
      tick(0, 1, 0);
      check("drain_dout", dout, i);
      check("drain_dv", dout_valid, 1);
      check("drain_cnt", count, 8 - i);
    end
    check("drain_empty", empty, 1);
    tick(0, 1, 0);
    check("udf_pulse", underflow, 1);
    check("udf_dv", dout_valid, 0);
    check("udf_dout", dout, 16'h0008);
    tick(0, 0, 0);
    check("udf_clear", underflow, 0);

    // 4: simultaneous read/write at count 4
    for (int i = 0; i < 4; i++)
      tick(1, 0, 16'h0010 + 16'(i));
    check("sim_pre_cnt", count, 4);
    for (int k = 0; k < 5; k++) begin
      tick(1, 1, 16'h0020 + 16'(k));
      exp_w = (k < 4) ? 16'h0010 + 16'(k)
                      : 16'h0020;
      check("sim_cnt", count, 4);
      check("sim_ack", wr_ack, 1);
      check("sim_dv", dout_valid, 1);
      check("sim_dout", dout, exp_w);
    end
    for (int k = 1; k <= 4; k++) begin
      tick(0, 1, 0);
      check("sim_tail", dout, 16'h0020 + 16'(k));
    end
    check("sim_empty", empty, 1);

    // 5a: full with both requests
    for (int i = 0; i < 8; i++)
      tick(1, 0, 16'h0030 + 16'(i));
    check("f5_full", full, 1);
    tick(1, 1, 16'h0099);
    check("f5_ovf", overflow, 1);
    check("f5_ack", wr_ack, 0);
    check("f5_dv", dout_valid, 1);
    check("f5_dout", dout, 16'h0030);
    check("f5_cnt", count, 7);
    for (int i = 1; i < 8; i++)
      tick(0, 1, 0);
    check("f5_last", dout, 16'h0037);
    check("f5_empty", empty, 1);

    // 5b: empty with both requests
    tick(1, 1, 16'h0055);
    check("e5_udf", underflow, 1);
    check("e5_ack", wr_ack, 1);
    check("e5_dv", dout_valid, 0);
    check("e5_cnt", count, 1);
    tick(0, 1, 0);
    check("e5_dout", dout, 16'h0055);
    check("e5_empty", empty, 1);

    // 6: stream with gaps, reset at count 5
    q.delete();
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 2))
        tick(0, 0, 0);
      if (k < 5) begin
        tick(1, 0, 16'h0100 + 16'(k));
        q.push_back(16'h0100 + 16'(k));
      end else begin
        tick(1, 1, 16'h0100 + 16'(k));
        q.push_back(16'h0100 + 16'(k));
        exp_w = q.pop_front();
        check("str_dout", dout, exp_w);
        check("str_dv", dout_valid, 1);
      end
    end
    check("str_cnt", count, 5);
    rst = 1'b1;
    tick(0, 0, 0);
    rst = 1'b0;
    check("mrst_cnt", count, 0);
    check("mrst_empty", empty, 1);
    check("mrst_dout", dout, 0);
    check("mrst_dv", dout_valid, 0);
    tick(1, 0, 16'habcd);
    check("post_cnt", count, 1);
    tick(0, 1, 0);
    check("post_dout", dout, 16'habcd);
    check("post_dv", dout_valid, 1);
    check("post_empty", empty, 1);

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
